// File: rtl/aes_spi_if.sv
// SPI slave front-end for a 128-bit block cipher core.
// The MCU shifts in 256 bits (key then plaintext) in SPI mode 0. A well-framed
// transfer pulses load to the core; the core result is captured on done and is
// shifted out on sdo during the next transfer (full duplex).
// Optional build macro: AES_SPI_IF_TIMEOUT_EN adds a 200-cycle watchdog on the
// wait-for-done state.
module aes_spi_if (
  input  logic         clk,
  input  logic         rst,
  input  logic         sck,
  input  logic         cs_n,
  input  logic         sdi,
  output logic         sdo,
  output logic [127:0] key,
  output logic [127:0] plaintext,
  output logic         load,
  input  logic         done,
  input  logic [127:0] cyphertext,
  output logic         ready,
  output logic         err
);

  typedef enum logic [2:0] {StIdle, StShift, StLoad, StWait, StReady} state_e;

  state_e       state_q, state_d;
  // Synchronizer chains: [0] first flop, [1] second flop, [2] previous value for edge detect.
  logic [2:0]   sck_sync_q, sck_sync_d;
  logic [2:0]   cs_sync_q, cs_sync_d;
  logic [1:0]   sdi_sync_q, sdi_sync_d;
  logic [8:0]   cnt_q, cnt_d;
  logic [255:0] in_q, in_d;
  logic [127:0] out_q, out_d;
  logic [127:0] key_q, key_d;
  logic [127:0] pt_q, pt_d;
  logic         sdo_q, sdo_d;
  logic         load_q, load_d;
  logic         ready_q, ready_d;
  logic         err_q, err_d;
`ifdef AES_SPI_IF_TIMEOUT_EN
  logic [7:0]   wd_q, wd_d;
`endif

  logic sck_rise, sck_fall, cs_fall, cs_rise, sdi_s;

  assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2];
  assign cs_fall  = ~cs_sync_q[1] & cs_sync_q[2];
  assign cs_rise  = cs_sync_q[1] & ~cs_sync_q[2];
  assign sdi_s    = sdi_sync_q[1];

  // Next-state: synchronizers, transfer FSM, shift registers and registered outputs.
  always_comb begin
    sck_sync_d = {sck_sync_q[1:0], sck};
    cs_sync_d  = {cs_sync_q[1:0], cs_n};
    sdi_sync_d = {sdi_sync_q[0], sdi};
    state_d    = state_q;
    cnt_d      = cnt_q;
    in_d       = in_q;
    out_d      = out_q;
    key_d      = key_q;
    pt_d       = pt_q;
    sdo_d      = sdo_q;
    ready_d    = ready_q;
    err_d      = err_q;
`ifdef AES_SPI_IF_TIMEOUT_EN
    wd_d       = wd_q;
`endif

    unique case (state_q)
      StIdle, StReady: begin
        if (cs_fall) begin
          state_d = StShift;
          cnt_d   = '0;
          ready_d = 1'b0;
          // Mode 0: first output bit must be on sdo before the first sck rise.
          sdo_d   = out_q[127];
          out_d   = {out_q[126:0], 1'b0};
        end
      end
      StShift: begin
        if (cs_rise) begin
          if (cnt_q == 9'd256) begin
            state_d = StLoad;
            key_d   = in_q[255:128];
            pt_d    = in_q[127:0];
            err_d   = 1'b0;
          end else begin
            state_d = StIdle;
            err_d   = 1'b1;
          end
        end else begin
          if (sck_rise) begin
            in_d = {in_q[254:0], sdi_s};
            if (cnt_q != 9'h1ff) cnt_d = cnt_q + 9'd1;
          end
          if (sck_fall) begin
            sdo_d = out_q[127];
            out_d = {out_q[126:0], 1'b0};
          end
        end
      end
      StLoad: begin
        state_d = StWait;
        if (cs_fall) err_d = 1'b1;
`ifdef AES_SPI_IF_TIMEOUT_EN
        wd_d = '0;
`endif
      end
      StWait: begin
        if (cs_fall) err_d = 1'b1;
        if (done) begin
          out_d   = cyphertext;
          state_d = StReady;
          ready_d = 1'b1;
        end
`ifdef AES_SPI_IF_TIMEOUT_EN
        else if (wd_q == 8'd199) begin
          state_d = StIdle;
          err_d   = 1'b1;
          ready_d = 1'b0;
        end else begin
          wd_d = wd_q + 8'd1;
        end
`endif
      end
      default: state_d = StIdle;
    endcase

    load_d = (state_d == StLoad);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      sck_sync_q <= '0;
      cs_sync_q  <= '0;
      sdi_sync_q <= '0;
      cnt_q      <= '0;
      in_q       <= '0;
      out_q      <= '0;
      key_q      <= '0;
      pt_q       <= '0;
      sdo_q      <= 1'b0;
      load_q     <= 1'b0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
`ifdef AES_SPI_IF_TIMEOUT_EN
      wd_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sck_sync_q <= sck_sync_d;
      cs_sync_q  <= cs_sync_d;
      sdi_sync_q <= sdi_sync_d;
      cnt_q      <= cnt_d;
      in_q       <= in_d;
      out_q      <= out_d;
      key_q      <= key_d;
      pt_q       <= pt_d;
      sdo_q      <= sdo_d;
      load_q     <= load_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
`ifdef AES_SPI_IF_TIMEOUT_EN
      wd_q       <= wd_d;
`endif
    end
  end

  assign sdo       = sdo_q;
  assign key       = key_q;
  assign plaintext = pt_q;
  assign load      = load_q;
  assign ready     = ready_q;
  assign err       = err_q;

endmodule

// File: tb/tb_aes_spi_if.sv
// Directed bench for aes_spi_if: a table of SPI transfers plus hand-written
// sequences for error framing, cs_n during WAIT, mid-transfer reset and WAIT timeout.
module tb_aes_spi_if;

  logic         clk = 1'b0;
  logic         rst;
  logic         sck, cs_n, sdi;
  logic         sdo;
  logic [127:0] key, plaintext;
  logic         load;
  logic         done;
  logic [127:0] cyphertext;
  logic         ready, err;

  int total = 0;
  int bad   = 0;
  int load_cnt = 0;
  int l0;
  logic [127:0] rd;

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2  = 128'hfedcba98765432100123456789abcdef;
  localparam logic [127:0] P2  = 128'ha5a55a5a3c3cc3c30ff0f00f12345678;
  localparam logic [127:0] CT2 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

  typedef struct {
    int           nbits;
    logic [511:0] data;
    bit           do_done;
    logic [127:0] ct;
    logic [127:0] exp_rd;
    int           exp_loads;
    logic         exp_err;
    logic [127:0] exp_key;
    logic [127:0] exp_pt;
  } vec_t;

  vec_t vecs[5];

  aes_spi_if dut (
    .clk        (clk),
    .rst        (rst),
    .sck        (sck),
    .cs_n       (cs_n),
    .sdi        (sdi),
    .sdo        (sdo),
    .key        (key),
    .plaintext  (plaintext),
    .load       (load),
    .done       (done),
    .cyphertext (cyphertext),
    .ready      (ready),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Count cycles with load high, sampled away from the active edge.
  always @(negedge clk) if (load === 1'b1) load_cnt++;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sdo"}, 128'(sdo), '0);
    check({tag, "_key"}, key, '0);
    check({tag, "_pt"}, plaintext, '0);
    check({tag, "_load"}, 128'(load), '0);
    check({tag, "_ready"}, 128'(ready), '0);
    check({tag, "_err"}, 128'(err), '0);
  endtask

  // SPI mode 0 master; sends data[nbits-1:0] MSB first, captures first 128 sdo bits.
  task automatic xfer(input int nbits, input logic [511:0] data, input int rst_at,
                      output logic [127:0] rdo);
    rdo = '0;
    @(negedge clk);
    cs_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rst = 1'b0;
        #1;
        check_all_zero("midrst");
        sck  = 1'b0;
        cs_n = 1'b1;
        sdi  = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        return;
      end
      sdi = data[nbits-1-i];
      repeat (4) @(negedge clk);
      if (i < 128) rdo = {rdo[126:0], sdo};
      sck = 1'b1;
      repeat (4) @(negedge clk);
      sck = 1'b0;
    end
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    sdi  = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic core_done(input logic [127:0] ct);
    @(negedge clk);
    done       = 1'b1;
    cyphertext = ct;
    @(negedge clk);
    done       = 1'b0;
    cyphertext = ~ct;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{256, {256'b0, K1, P1}, 1'b1, CT,  '0,  1, 1'b0, K1, P1};
    vecs[1] = '{256, {256'b0, K2, P2}, 1'b1, CT2, CT,  1, 1'b0, K2, P2};
    vecs[2] = '{255, {256'b0, K1, P1}, 1'b0, '0,  CT2, 0, 1'b1, K2, P2};
    vecs[3] = '{257, {255'b0, 1'b1, K1, P1}, 1'b0, '0, '0, 0, 1'b1, K2, P2};
    vecs[4] = '{256, {256'b0, K1, P1}, 1'b1, CT,  '0,  1, 1'b0, K1, P1};

    rst = 1'b0; sck = 1'b0; cs_n = 1'b1; sdi = 1'b0; done = 1'b0; cyphertext = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // done outside WAIT must be ignored (v0 then reads back zeros).
    core_done(CT);
    check("done_idle_ready", 128'(ready), '0);

    for (int v = 0; v < 5; v++) begin
      // sck activity with cs_n high must not shift anything.
      repeat (3) begin
        sck = 1'b1; repeat (2) @(negedge clk);
        sck = 1'b0; repeat (2) @(negedge clk);
      end
      l0 = load_cnt;
      xfer(vecs[v].nbits, vecs[v].data, -1, rd);
      check($sformatf("v%0d_sdo", v), rd, vecs[v].exp_rd);
      check($sformatf("v%0d_loads", v), 128'(load_cnt - l0), 128'(vecs[v].exp_loads));
      check($sformatf("v%0d_err", v), 128'(err), 128'(vecs[v].exp_err));
      check($sformatf("v%0d_key", v), key, vecs[v].exp_key);
      check($sformatf("v%0d_pt", v), plaintext, vecs[v].exp_pt);
      check($sformatf("v%0d_ready_pre", v), 128'(ready), '0);
      if (vecs[v].do_done) begin
        core_done(vecs[v].ct);
        check($sformatf("v%0d_ready", v), 128'(ready), 128'd1);
      end
    end

    // cs_n activity during WAIT: flagged, ignored, result still captured.
    l0 = load_cnt;
    xfer(256, {256'b0, K2, P2}, -1, rd);
    check("w_sdo", rd, CT);
    check("w_loads", 128'(load_cnt - l0), 128'd1);
    @(negedge clk);
    cs_n = 1'b0;
    repeat (8) begin
      sdi = 1'b1;
      repeat (4) @(negedge clk); sck = 1'b1;
      repeat (4) @(negedge clk); sck = 1'b0;
    end
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    sdi  = 1'b0;
    repeat (10) @(negedge clk);
    check("w_err", 128'(err), 128'd1);
    check("w_ready_pre", 128'(ready), '0);
    check("w_key", key, K2);
    check("w_loads2", 128'(load_cnt - l0), 128'd1);
    core_done(CT2);
    check("w_ready", 128'(ready), 128'd1);
    l0 = load_cnt;
    xfer(256, {256'b0, K1, P1}, -1, rd);
    check("w_readback", rd, CT2);
    check("w_next_key", key, K1);
    check("w_next_err", 128'(err), '0);
    check("w_next_loads", 128'(load_cnt - l0), 128'd1);
    core_done(CT);

    // Reset at bit 100 of a transfer: everything cleared, no load afterwards.
    l0 = load_cnt;
    xfer(256, {256'b0, K2, P2}, 100, rd);
    repeat (30) @(negedge clk);
    check("r_loads", 128'(load_cnt - l0), '0);
    check("r_key", key, '0);
    check("r_ready", 128'(ready), '0);
    xfer(256, {256'b0, K2, P2}, -1, rd);
    check("r_sdo", rd, '0);
    check("r_loads2", 128'(load_cnt - l0), 128'd1);
    check("r_key2", key, K2);
    check("r_pt2", plaintext, P2);
    check("r_err2", 128'(err), '0);

    // No done after load: watchdog expiry or indefinite WAIT.
`ifdef AES_SPI_IF_TIMEOUT_EN
    repeat (250) @(negedge clk);
    check("t_err", 128'(err), 128'd1);
    check("t_ready", 128'(ready), '0);
    core_done(CT);
    check("t_done_ignored", 128'(ready), '0);
`else
    repeat (1000) @(negedge clk);
    check("t_err", 128'(err), '0);
    check("t_ready", 128'(ready), '0);
    core_done(CT2);
    check("t_late_done", 128'(ready), 128'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_spi_if.md
AES_SPI_IF -- requirements
Module: aes_spi_if

Interface
REQ-001 SHALL have port clk, input, 1, sole system clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1; reset is asynchronous and active-low.
REQ-003 SHALL have port sck, input, 1, SPI serial clock from MCU, asynchronous to clk.
REQ-004 SHALL have port cs_n, input, 1, SPI chip select, active-low, asynchronous.
REQ-005 SHALL have port sdi, input, 1, SPI data in, MSB first.
REQ-006 SHALL have port sdo, output, 1, SPI data out, MSB first.
REQ-007 SHALL have port key, output, 128, key presented to encryption core.
REQ-008 SHALL have port plaintext, output, 128, block presented to encryption core.
REQ-009 SHALL have port load, output, 1, one-cycle start pulse to core.
REQ-010 SHALL have port done, input, 1, core completion strobe.
REQ-011 SHALL have port cyphertext, input, 128, core result, valid while done=1.
REQ-012 SHALL have port ready, output, 1, result available for readout.
REQ-013 SHALL have port err, output, 1, sticky framing/protocol error flag.

Function
REQ-014 SHALL pass sck, cs_n, sdi each through a 2-flop synchronizer; edges detected on synchronized sck (max sck = clk/4).
REQ-015 SHALL use SPI mode 0: sample sdi on synchronized sck rising edge; update sdo on synchronized sck falling edge.
REQ-016 SHALL implement FSM states IDLE, SHIFT, LOAD, WAIT, READY.
REQ-017 IDLE->SHIFT on synchronized cs_n falling edge; bit counter (9 bits) cleared; ready cleared.
REQ-018 In SHIFT, each sampled bit SHALL shift into 256-bit input register; counter increments, saturating at 511.
REQ-019 SHIFT on cs_n rising edge: count==256 -> LOAD, with key=first 128 bits and plaintext=last 128 bits; otherwise -> IDLE, err set, key/plaintext unchanged.
REQ-020 LOAD SHALL assert load for exactly one cycle, then go to WAIT.
REQ-021 WAIT SHALL capture cyphertext into a 128-bit output register on the first cycle done=1, then go to READY with ready=1 the following cycle.
REQ-022 In READY, next cs_n falling edge SHALL clear ready, go to SHIFT, and shift the output register out on sdo, MSB first, while simultaneously shifting in new key/plaintext (full duplex).
REQ-023 Output register SHALL shift in zeros from LSB; sdo=0 after 128 bits shifted and before any capture.
REQ-024 cs_n falling edge during LOAD or WAIT SHALL be ignored (sdi not sampled), err set; FSM continues.
REQ-025 done asserted outside WAIT SHALL be ignored.
REQ-026 sck edges with cs_n high SHALL be ignored.
REQ-027 err SHALL clear only on reset or on a subsequent well-formed 256-bit transaction reaching LOAD.

Reset
REQ-028 rst low SHALL asynchronously force FSM to IDLE, counter 0, all registers 0.
REQ-029 Output reset values: sdo=0, key=0, plaintext=0, load=0, ready=0, err=0.
REQ-030 Reset mid-transaction or mid-WAIT SHALL discard partial data; no load pulse after release.

Configuration
REQ-031 Macro AES_SPI_IF_TIMEOUT_EN SHALL, when defined, add an 8-bit WAIT watchdog: done absent 200 clk cycles after load -> IDLE, err=1, ready=0.
REQ-032 Without AES_SPI_IF_TIMEOUT_EN, WAIT SHALL persist indefinitely until done or reset.

Verification
REQ-033 Shift key 000102030405060708090a0b0c0d0e0f then plaintext 00112233445566778899aabbccddeeff -> one load pulse, key/plaintext match, err=0.
REQ-034 Core model returns 69c4e0d86a7b0430d8cdb78070b4c55a with done -> ready=1; next 256-bit transaction reads sdo first 128 bits = 69c4...c55a.
REQ-035 Transaction of 255 bits, then of 257 bits -> no load pulse either time, err=1, key unchanged.
REQ-036 Assert rst low at bit 100 of transaction -> all outputs 0 immediately; after release, no load; next valid transaction works normally.
REQ-037 cs_n falls while in WAIT -> err=1, input register unchanged, cyphertext still captured on done, ready=1.
REQ-038 With AES_SPI_IF_TIMEOUT_EN, no done after load -> after 200 cycles err=1, state IDLE; without it, still in WAIT at 1000 cycles.
